// File: rtl/gowin_clk_pkg.sv
// Shared clocking definitions for the 81 MHz system domain: supervisor
// FSM states and the timebase constants derived from the PLL output clock.
package gowin_clk_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        RUN       = 2'd2
    } pls_state_t;

    localparam int CLK_HZ = 81_000_000;
    localparam int US_DIV = 81;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level into the clk domain.
// Clears to 0 on synchronous active-low reset.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d_i;
            r_sync <= r_meta;
        end
    end

    assign q_o = r_sync;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Holds the system domain in reset until PLL lock has been stable long enough,
// then runs a 1 us tick timebase and counts later lock losses.
module pll_lock_supervisor
    import gowin_clk_pkg::*;
#(
    parameter int STABLE_CYCLES = 8100,
    parameter int TICK_DIV      = US_DIV,
    parameter int LOSS_W        = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pll_lock_i,
    output logic              sys_rst_n_o,
    output logic              ready_o,
    output logic              tick_o,
    output logic [LOSS_W-1:0] loss_cnt_o,
    output logic [1:0]        state_o
);

    localparam int SW = $clog2(STABLE_CYCLES);
    localparam int TW = $clog2(TICK_DIV);
    localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic              w_lock_s;
    pls_state_t        r_state;
    pls_state_t        w_next;
    logic [SW-1:0]     r_stab;
    logic [SW-1:0]     w_stab_nxt;
    logic [TW-1:0]     r_tick_cnt;
    logic              r_sys_rst_n;
    logic              r_ready;
    logic              r_tick;
    logic [LOSS_W-1:0] r_loss;
    logic              w_run_now;
    logic              w_run_next;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (pll_lock_i),
        .q_o   (w_lock_s)
    );

    // Any sampled drop of lock_s sends the FSM back to WAIT_LOCK, so a
    // captured glitch always restarts stabilization from zero.
    always_comb begin
        w_next     = WAIT_LOCK;
        w_stab_nxt = '0;
        case (r_state)
            WAIT_LOCK: begin
                if (w_lock_s) w_next = STABILIZE;
            end
            STABILIZE: begin
                if (!w_lock_s) begin
                    w_next = WAIT_LOCK;
                end else if (r_stab == STAB_LAST) begin
                    w_next = RUN;
                end else begin
                    w_next     = STABILIZE;
                    w_stab_nxt = r_stab + SW'(1);
                end
            end
            RUN: begin
                w_next = w_lock_s ? RUN : WAIT_LOCK;
            end
            default: w_next = WAIT_LOCK;
        endcase
    end

    assign w_run_now  = (r_state == RUN);
    assign w_run_next = (w_next == RUN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= WAIT_LOCK;
            r_stab      <= '0;
            r_tick_cnt  <= '0;
            r_sys_rst_n <= 1'b0;
            r_ready     <= 1'b0;
            r_tick      <= 1'b0;
            r_loss      <= '0;
        end else begin
            r_state     <= w_next;
            r_stab      <= w_stab_nxt;
            r_sys_rst_n <= w_run_next;
            r_ready     <= w_run_next;

            // Leaving RUN on a wrap edge suppresses that tick.
            if (w_run_now && w_run_next) begin
                r_tick_cnt <= (r_tick_cnt == TICK_LAST) ? '0 : r_tick_cnt + TW'(1);
            end else begin
                r_tick_cnt <= '0;
            end
            r_tick <= w_run_now && w_run_next && (r_tick_cnt == TICK_LAST);

            if (w_run_now && !w_run_next && (r_loss != '1)) begin
                r_loss <= r_loss + LOSS_W'(1);
            end
        end
    end

    assign sys_rst_n_o = r_sys_rst_n;
    assign ready_o     = r_ready;
    assign tick_o      = r_tick;
    assign loss_cnt_o  = r_loss;
    assign state_o     = r_state;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed plus randomized bench for pll_lock_supervisor; expectations come
// from a lock-run-length model of the acquire/loss/tick timing rules.
module tb_pll_lock_supervisor;

    localparam int SC   = 16;
    localparam int TD   = 4;
    localparam int LW   = 2;
    localparam int LMAX = (1 << LW) - 1;

    logic          clk;
    logic          rst_n;
    logic          pll_lock_i;
    logic          sys_rst_n_o;
    logic          ready_o;
    logic          tick_o;
    logic [LW-1:0] loss_cnt_o;
    logic [1:0]    state_o;

    int total = 0;
    int bad   = 0;

    // Model: lock pipeline, run length of consecutive seen-lock edges, loss count.
    int m_meta  = 0;
    int m_sync  = 0;
    int m_run   = 0;
    int m_loss  = 0;
    int m_state = 0;
    int m_prev  = 0;

    pll_lock_supervisor #(
        .STABLE_CYCLES (SC),
        .TICK_DIV      (TD),
        .LOSS_W        (LW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pll_lock_i  (pll_lock_i),
        .sys_rst_n_o (sys_rst_n_o),
        .ready_o     (ready_o),
        .tick_o      (tick_o),
        .loss_cnt_o  (loss_cnt_o),
        .state_o     (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one edge, update the model from the inputs seen at that edge,
    // then compare every output 1 time unit later.
    task automatic step();
        int s;
        int t;
        int exp_tick;
        @(posedge clk);
        if (!rst_n) begin
            m_meta = 0;
            m_sync = 0;
            m_run  = 0;
            m_loss = 0;
            m_prev = 0;
        end else begin
            s      = m_sync;
            m_sync = m_meta;
            m_meta = pll_lock_i ? 1 : 0;
            m_run  = (s != 0) ? m_run + 1 : 0;
        end
        m_state = (m_run == 0) ? 0 : (m_run <= SC) ? 1 : 2;
        if (rst_n && m_prev == 2 && m_state != 2 && m_loss < LMAX) m_loss++;
        m_prev = m_state;
        t = m_run - SC - 1;
        exp_tick = (m_state == 2 && t > 0 && (t % TD) == 0) ? 1 : 0;
        #1;
        chk("m_state", state_o, m_state);
        chk("m_ready", ready_o, (m_state == 2) ? 1 : 0);
        chk("m_sysrst", sys_rst_n_o, (m_state == 2) ? 1 : 0);
        chk("m_tick", tick_o, exp_tick);
        chk("m_loss", loss_cnt_o, m_loss);
    endtask

    task automatic wait_run();
        for (int i = 0; i < 40 && m_state != 2; i++) step();
        chk("wait_run", ready_o, 1);
    endtask

    initial begin
        int exp_sat [5];
        exp_sat = '{1, 2, 3, 3, 3};

        // Reset with lock low, then idle
        rst_n = 1'b0;
        pll_lock_i = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (8) step();
        chk("idle_state", state_o, 0);
        chk("idle_ready", ready_o, 0);
        chk("idle_sysrst", sys_rst_n_o, 0);
        chk("idle_tick", tick_o, 0);
        chk("idle_loss", loss_cnt_o, 0);

        // Acquire to stab_cnt=10, glitch lock for 2 cycles, restore
        pll_lock_i = 1'b1;
        for (int e = 1; e <= 13; e++) begin
            step();
            if (e == 2) chk("pre_e2_state", state_o, 0);
            if (e == 3) chk("pre_e3_state", state_o, 1);
        end
        pll_lock_i = 1'b0;
        step();
        step();
        pll_lock_i = 1'b1;
        step();
        chk("glitch_state", state_o, 0);
        chk("glitch_loss", loss_cnt_o, 0);

        // Full re-stabilization counted from the restore edge (edge 1)
        for (int e = 2; e <= 31; e++) begin
            step();
            if (e == 3)  chk("acq_e3_state", state_o, 1);
            if (e == 18) chk("acq_e18_ready", ready_o, 0);
            if (e == 19) chk("acq_e19_ready", ready_o, 1);
            if (e == 19) chk("acq_e19_sysrst", sys_rst_n_o, 1);
            if (e == 22) chk("acq_e22_tick", tick_o, 0);
            if (e == 23 || e == 27 || e == 31) chk("acq_tick", tick_o, 1);
            if (e == 24) chk("acq_e24_tick", tick_o, 0);
        end

        // Lock loss from RUN at edge j
        repeat (2) step();
        pll_lock_i = 1'b0;
        step();
        step();
        chk("loss_j1_ready", ready_o, 1);
        step();
        chk("loss_j2_sysrst", sys_rst_n_o, 0);
        chk("loss_j2_loss", loss_cnt_o, 1);
        chk("loss_j2_tick", tick_o, 0);
        chk("loss_j2_state", state_o, 0);
        pll_lock_i = 1'b1;
        wait_run();

        // Reset asserted mid-RUN, then re-acquire with lock held
        repeat (3) step();
        rst_n = 1'b0;
        step();
        chk("rst_state", state_o, 0);
        chk("rst_ready", ready_o, 0);
        chk("rst_sysrst", sys_rst_n_o, 0);
        chk("rst_tick", tick_o, 0);
        chk("rst_loss", loss_cnt_o, 0);
        rst_n = 1'b1;
        for (int e = 1; e <= 19; e++) begin
            step();
            if (e == 18) chk("reacq_e18_ready", ready_o, 0);
            if (e == 19) chk("reacq_e19_ready", ready_o, 1);
        end

        // Five losses from RUN, counter saturates at LMAX
        for (int k = 0; k < 5; k++) begin
            repeat ($urandom_range(0, 6)) step();
            pll_lock_i = 1'b0;
            repeat ($urandom_range(1, 3)) step();
            pll_lock_i = 1'b1;
            step();
            step();
            chk("sat_loss", loss_cnt_o, exp_sat[k]);
            wait_run();
        end

        // Random lock bursts with occasional resets, checked against the model
        for (int it = 0; it < 40; it++) begin
            pll_lock_i = 1'b1;
            repeat ($urandom_range(1, 30)) step();
            pll_lock_i = 1'b0;
            repeat ($urandom_range(1, 4)) step();
            if ($urandom_range(0, 9) == 0) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
